// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types, defaults and helpers for the Fibonacci stream checker
package fib_pkg;

    localparam int FIB_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } fib_state_t;

    function automatic int fib_clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/fib_sync_fifo.sv
// rtl/fib_sync_fifo.sv - first-word-fall-through synchronous FIFO with flush
module fib_sync_fifo
    import fib_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = FIB_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [fib_clog2(DEPTH):0] count
);

    localparam int AW = fib_clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = cnt;

    // When empty the output holds the most recently popped word instead of a stale slot.
    assign pop_data = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fib_stream_checker.sv
// rtl/fib_stream_checker.sv - checks an incoming Fibonacci stream and buffers it in a FIFO
module fib_stream_checker
    import fib_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = FIB_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic                      seq_err,
    output logic                      ovf,
    output logic [fib_clog2(DEPTH):0] count
);

    fib_state_t       state;
    logic [WIDTH-1:0] p1;
    logic [WIDTH-1:0] p2;
    logic [WIDTH:0]   exp_sum;
    logic             carry;
    logic             mismatch;
    logic             accept;
    logic             push;
    logic             full;
    logic             empty;

    assign exp_sum  = {1'b0, p1} + {1'b0, p2};
    assign carry    = exp_sum[WIDTH];
    assign mismatch = (in_data != exp_sum[WIDTH-1:0]);

    // Ready depends only on registered state and the reset pin, never on out_ready.
    assign in_ready  = rst && !full && (state != HALT);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !((state == RUN) && carry);
    assign out_valid = !empty;

    fib_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .push_data (in_data),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            p1      <= '0;
            p2      <= '0;
            seq_err <= 1'b0;
            ovf     <= 1'b0;
        end else if (clr) begin
            state   <= IDLE;
            p1      <= '0;
            p2      <= '0;
            seq_err <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    p1    <= in_data;
                    state <= PRIME;
                end
                PRIME: begin
                    p2    <= p1;
                    p1    <= in_data;
                    state <= RUN;
                end
                RUN: begin
                    // An overflowing sum ends the stream; the offending sample is dropped.
                    if (carry) begin
                        ovf   <= 1'b1;
                        state <= HALT;
                    end else begin
                        if (mismatch) begin
                            seq_err <= 1'b1;
                        end
                        p2 <= p1;
                        p1 <= in_data;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_stream_checker.sv
// tb/tb_fib_stream_checker.sv - directed self-checking bench for fib_stream_checker
module tb_fib_stream_checker;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic             seq_err;
    logic             ovf;
    logic [3:0]       count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fib_stream_checker #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .seq_err   (seq_err),
        .ovf       (ovf),
        .count     (count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr;
        clr = 1'b1;
        in_valid = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready actual=%0b expected=0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid actual=%0b expected=0", out_valid); end
        checks++;
        if (out_data !== 32'd0) begin failures++; $display("FAIL reset_out_data actual=%0d expected=0", out_data); end
        checks++;
        if (count !== 4'd0) begin failures++; $display("FAIL reset_count actual=%0d expected=0", count); end
        checks++;
        if (seq_err !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL reset_flags actual=%0b%0b expected=00", seq_err, ovf); end
        rst = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready actual=%0b expected=1", in_ready); end
    endtask

    task automatic test_fib_stream;
        logic [31:0] seq [7];
        seq = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data = seq[i];
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] actual=%0b expected=1", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== seq[i]) begin
                failures++; $display("FAIL stream_out[%0d] actual=%0b/%0d expected=1/%0d", i, out_valid, out_data, seq[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL stream_drained actual=%0b/%0d expected=0/0", out_valid, count); end
        checks++;
        if (seq_err !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL stream_flags actual=%0b%0b expected=00", seq_err, ovf); end
        do_clr();
    endtask

    task automatic test_seq_err;
        logic [31:0] seq [6];
        seq = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd4, 32'd6};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data = seq[i];
            tick();
            checks++;
            if (seq_err !== (i >= 4)) begin failures++; $display("FAIL seqerr_flag[%0d] actual=%0b expected=%0b", i, seq_err, (i >= 4)); end
            checks++;
            if (out_data !== seq[i]) begin failures++; $display("FAIL seqerr_out[%0d] actual=%0d expected=%0d", i, out_data, seq[i]); end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (seq_err !== 1'b1) begin failures++; $display("FAIL seqerr_sticky actual=%0b expected=1", seq_err); end
        do_clr();
        checks++;
        if (seq_err !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL seqerr_clr actual=%0b/%0d expected=0/0", seq_err, count); end
    endtask

    task automatic test_overflow;
        logic [31:0] seq [3];
        seq = '{32'd1134903170, 32'd1836311903, 32'd2971215073};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = seq[i];
            tick();
        end
        checks++;
        if (count !== 4'd3 || seq_err !== 1'b0) begin failures++; $display("FAIL ovf_prefill actual=%0d/%0b expected=3/0", count, seq_err); end
        in_data = 32'd512559680;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL ovf_ready_before actual=%0b expected=1", in_ready); end
        tick();
        checks++;
        if (ovf !== 1'b1 || count !== 4'd3 || in_ready !== 1'b0) begin
            failures++; $display("FAIL ovf_trip actual=ovf%0b/cnt%0d/rdy%0b expected=ovf1/cnt3/rdy0", ovf, count, in_ready);
        end
        tick();
        checks++;
        if (count !== 4'd3) begin failures++; $display("FAIL ovf_halt_count actual=%0d expected=3", count); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== seq[i]) begin
                failures++; $display("FAIL ovf_drain[%0d] actual=%0b/%0d expected=1/%0d", i, out_valid, out_data, seq[i]);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || ovf !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL ovf_after_drain actual=val%0b/ovf%0b/rdy%0b expected=val0/ovf1/rdy0", out_valid, ovf, in_ready);
        end
        do_clr();
        checks++;
        if (ovf !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL ovf_clr actual=ovf%0b/rdy%0b expected=ovf0/rdy1", ovf, in_ready); end
    endtask

    task automatic test_full;
        logic [31:0] seq [10];
        int idx;
        int accepted;
        seq = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34};
        idx = 0;
        accepted = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data = seq[idx];
            if (in_ready === 1'b1) begin
                accepted++;
                idx++;
            end
            tick();
        end
        checks++;
        if (accepted != 8) begin failures++; $display("FAIL full_accepted actual=%0d expected=8", accepted); end
        checks++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin failures++; $display("FAIL full_state actual=cnt%0d/rdy%0b expected=cnt8/rdy0", count, in_ready); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd0) begin failures++; $display("FAIL full_head actual=%0b/%0d expected=1/0", out_valid, out_data); end
    endtask

    task automatic test_full_push_pop;
        logic [31:0] rest [7];
        rest = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13};
        in_valid = 1'b1;
        in_data = 32'd21;
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL fullpp_ready actual=%0b expected=0", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 4'd7) begin failures++; $display("FAIL fullpp_count actual=%0d expected=7", count); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== rest[i]) begin
                failures++; $display("FAIL fullpp_drain[%0d] actual=%0b/%0d expected=1/%0d", i, out_valid, out_data, rest[i]);
            end
            tick();
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 4'd0 || out_data !== 32'd13) begin
            failures++; $display("FAIL empty_pop_hold actual=%0b/%0d/%0d expected=0/0/13", out_valid, count, out_data);
        end
        checks++;
        if (seq_err !== 1'b0) begin failures++; $display("FAIL fullpp_seq_err actual=%0b expected=0", seq_err); end
        out_ready = 1'b0;
        do_clr();
    endtask

    task automatic test_mid_reset;
        logic [31:0] seq [5];
        seq = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3};
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = seq[i];
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 4'd5) begin failures++; $display("FAIL midrst_fill actual=%0d expected=5", count); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL midrst_async actual=cnt%0d/val%0b/data%0d/rdy%0b expected=0/0/0/0", count, out_valid, out_data, in_ready);
        end
        rst = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = seq[i];
            tick();
            checks++;
            if (out_data !== seq[i] || seq_err !== 1'b0) begin
                failures++; $display("FAIL midrst_restream[%0d] actual=%0d/%0b expected=%0d/0", i, out_data, seq_err, seq[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fib_stream();
        test_seq_err();
        test_overflow();
        test_full();
        test_full_push_pop();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
